// File: rtl/int_controller.sv
// int_controller
//
// Purpose:
//   Latches rising edges on the peripheral interrupt lines and applies a
//   software-loaded enable mask. It picks the lowest-index enabled pending
//   line and handshakes an interrupt request plus handler vector with the
//   control unit. It asks the flags register to mask interrupts (flags[2])
//   on entry and to unmask them on return-from-interrupt.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   irq         interrupt lines, rising-edge sensitive
//   en_load     load enable mask from bus1[NUM_IRQ-1:0]
//   bus1        data bus
//   flags       CPU flags register; only flags[2] (1 = masked) is used
//   int_ack     control unit accepts the current request
//   reti        control unit executing return-from-interrupt
//   int_req     interrupt request to the control unit
//   int_vector  handler address, valid while int_req = 1
//   mask_int    one-cycle pulse to set flags[2]
//   unmask_int  one-cycle pulse to clear flags[2]
//   active      a handler is in service
//   active_id   index of the line in service or requested
//   pending     latched, not yet serviced edges
module int_controller #(
    parameter int          NUM_IRQ      = 4,
    parameter logic [15:0] VECTOR_BASE  = 16'h0010,
    parameter int          VECTOR_SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               en_load,
    input  logic [15:0]        bus1,
    input  logic [15:0]        flags,
    input  logic               int_ack,
    input  logic               reti,
    output logic               int_req,
    output logic [15:0]        int_vector,
    output logic               mask_int,
    output logic               unmask_int,
    output logic               active,
    output logic [3:0]         active_id,
    output logic [NUM_IRQ-1:0] pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [15:0]        vector_q, vector_d;
    logic [3:0]         id_q, id_d;
    logic               mask_q, mask_d;
    logic               unmask_q, unmask_d;

    logic [NUM_IRQ-1:0] cand;
    logic               cand_found;
    logic [3:0]         cand_idx;
    logic [15:0]        cand_vector;
    logic [NUM_IRQ-1:0] clear;
    logic               masked;

    // Only part of bus1 and a single bit of flags are meaningful here.
    logic unused_inputs;
    assign unused_inputs = ^{bus1, flags};

    assign masked = flags[2];

    // Lowest index wins: scan from the top so the last hit is the lowest.
    always_comb begin
        cand       = pending_q & enable_q;
        cand_found = |cand;
        cand_idx   = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                cand_idx = 4'(i);
            end
        end
        cand_vector = VECTOR_BASE + (16'(cand_idx) << VECTOR_SHIFT);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        vector_d = vector_q;
        mask_d   = 1'b0;
        unmask_d = 1'b0;
        clear    = '0;

        case (state_q)
            IDLE: begin
                if (cand_found && !masked) begin
                    state_d  = REQ;
                    id_d     = cand_idx;
                    vector_d = cand_vector;
                end
            end
            REQ: begin
                // id/vector stay frozen here; ack beats a late software mask.
                if (int_ack) begin
                    state_d = SERVICE;
                    mask_d  = 1'b1;
                    clear   = NUM_IRQ'(1) << id_q;
                end else if (masked) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (reti) begin
                    state_d  = IDLE;
                    unmask_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new edge on the bit being cleared is kept (set wins).
        pending_d = (pending_q & ~clear) | (irq & ~irq_prev_q);
        enable_d  = en_load ? bus1[NUM_IRQ-1:0] : enable_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            irq_prev_q <= '0;
            pending_q  <= '0;
            enable_q   <= '0;
            vector_q   <= VECTOR_BASE;
            id_q       <= 4'd0;
            mask_q     <= 1'b0;
            unmask_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            vector_q   <= vector_d;
            id_q       <= id_d;
            mask_q     <= mask_d;
            unmask_q   <= unmask_d;
        end
    end

    // Every output comes straight from a register or a state decode.
    assign int_req    = (state_q == REQ);
    assign active     = (state_q == SERVICE);
    assign int_vector = vector_q;
    assign active_id  = id_q;
    assign mask_int   = mask_q;
    assign unmask_int = unmask_q;
    assign pending    = pending_q;

endmodule

// File: doc/int_controller.md
# int_controller

Interrupt controller that consumes the interrupt-mask bit (flags[2]) of the CPU flags register and drives the mask_int / unmask_int requests that set and clear it. It latches rising edges on external interrupt lines, applies a software-loaded enable mask, and selects the highest-priority pending line. It handshakes an interrupt request and vector with the control unit, auto-masks on entry and unmasks on return-from-interrupt. It sits between the peripheral irq lines, the control FSM and the flags register.

## Interface
- NUM_IRQ, 4, number of interrupt lines (1..16)
- VECTOR_BASE, 16'h0010, handler address for line 0
- VECTOR_SHIFT, 2, log2 of the spacing between handler addresses

- clk  in  1  system clock, all logic on posedge
- rst  in  1  reset; synchronous, active-high
- irq  in  NUM_IRQ  interrupt lines, synchronous to clk, rising-edge sensitive
- en_load  in  1  load the enable mask from bus1
- bus1  in  16  data bus; bus1[NUM_IRQ-1:0] is the enable mask on en_load
- flags  in  16  flags register; only flags[2] (1 = interrupts masked) is used
- int_ack  in  1  control unit accepts the current request
- reti  in  1  control unit executing return-from-interrupt
- int_req  out  1  interrupt request to the control unit
- int_vector  out  16  handler address, valid while int_req = 1
- mask_int  out  1  one-cycle pulse to set flags[2]
- unmask_int  out  1  one-cycle pulse to clear flags[2]
- active  out  1  a handler is in service
- active_id  out  4  index of the line in service or requested
- pending  out  NUM_IRQ  latched, not yet serviced edges

## Operation
- Edge detect: irq_prev registers irq each cycle. Each cycle, pending <= (pending & ~clear) | (irq & ~irq_prev). Set wins over clear on the same bit in the same cycle.
- Enable register: en_load=1 loads bus1[NUM_IRQ-1:0]. Disabled lines still latch pending but are not requested.
- Candidate = pending & enable. Priority goes to the lowest index. Vector = VECTOR_BASE + (index << VECTOR_SHIFT), 16-bit, wraps modulo 2^16.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if the candidate is nonzero and flags[2]=0, latch the index into active_id and the vector into int_vector, then go to REQ.
  - REQ: int_req=1. active_id and int_vector stay frozen even if a higher-priority line becomes pending.
    - If int_ack=1: go to SERVICE and clear the pending bit of active_id.
    - Else if flags[2]=1 (software masked): drop int_req and return to IDLE. The pending bit is retained.
  - SERVICE: active=1. mask_int pulses for exactly one cycle, the first cycle in SERVICE. When reti=1: go to IDLE and pulse unmask_int for exactly one cycle, on the first cycle back in IDLE.
- reti outside SERVICE is ignored. int_ack outside REQ is ignored. No nesting: new edges during SERVICE only latch into pending.
- en_load during REQ or SERVICE updates the mask but does not affect the request or service in progress.
- Reset (any state): state=IDLE and all registers cleared, including pending, irq_prev and enable (=0). Reset mid-service drops the handler without an unmask_int pulse.

## Timing
- Reset values: int_req=0, int_vector=VECTOR_BASE, mask_int=0, unmask_int=0, active=0, active_id=0, pending=0.
- Edge and request latency:
  - A rising edge is sampled at posedge N.
  - The pending bit is set at N+1.
  - int_req is high from N+2 if the line is enabled and flags[2]=0.
- Acknowledge: int_ack sampled high at posedge A gives active=1, mask_int=1 and the pending bit cleared, all during A+1. flags[2] reads 1 from A+2.
- Return: reti sampled at posedge R gives active=0 and unmask_int=1 during R+1. flags[2] reads 0 from R+2. The earliest next int_req is R+3.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Single irq: after reset, en_load with bus1=16'h000F; pulse irq[2] -> int_req high 2 cycles after the edge, int_vector=16'h0018, active_id=2. Ack -> mask_int pulses once, pending[2]=0. reti -> unmask_int pulses once, active=0.
- Priority: raise irq[3] and irq[1] on the same cycle -> line 1 is serviced first (vector 16'h0014). After reti and flags[2] clearing, line 3 is requested (vector 16'h001C), with int_req at R+3.
- Masked: hold flags[2]=1 and pulse irq[0] -> pending[0]=1, int_req stays 0. Clear flags[2] -> int_req on the next-but-one cycle. Set flags[2] during REQ -> int_req drops and pending[0] remains 1.
- Disabled line: enable=16'h0001, pulse irq[1] -> pending[1]=1, no int_req. Then en_load 16'h0002 -> request with vector 16'h0014.
- Simultaneous: a new irq[0] edge on the ack cycle of line 0 -> pending[0] stays 1 and is re-requested after reti. reti while IDLE -> no unmask_int pulse.
- Reset mid-service: assert rst while in SERVICE -> the next cycle shows all outputs at reset values, with pending=0 and enable=0.
